uart_rx_buffer: RTL

//  Receive-side elastic buffer directly downstream of the UART receiver.
//  - Captures each received byte on its single-cycle data-valid strobe into a DEPTH-entry FIFO.
//  - Presents bytes to the consumer over a first-word-fall-through valid/ready interface.
//  - Reports overflow (sticky flag plus saturating drop counter) and counts framing errors.

---
 rtl/uart_rx_buffer_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 90 +++++++++
 rtl/uart_rx_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_buffer_pkg
//  Description : Shared default parameters and type definitions for the
//                UART receive-side elastic buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_buffer_pkg;

    // Default byte width; must match the upstream UART receiver.
    localparam int c_DEF_DATA_WIDTH = 8;
    // Default FIFO depth; power of two, at least 2.
    localparam int c_DEF_DEPTH      = 16;
    // Default width of the saturating status counters.
    localparam int c_DEF_CNT_WIDTH  = 8;

    // What happens to the byte arriving on the receiver strobe this cycle.
    typedef enum logic [1:0] {
        ACT_IDLE = 2'd0,   // no byte offered
        ACT_PUSH = 2'd1,   // byte written into the FIFO
        ACT_DROP = 2'd2    // byte discarded, FIFO full with no pop
    } rx_action_e;

endpackage : uart_rx_buffer_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Generic single-clock FIFO, DEPTH x DATA_WIDTH, with
//                first-word-fall-through read data and registered occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import uart_rx_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH  = c_DEF_DATA_WIDTH,
    parameter  int DEPTH       = c_DEF_DEPTH,
    localparam int ADDR_WIDTH  = $clog2(DEPTH),
    localparam int COUNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [DATA_WIDTH-1:0]  i_push_data,
    input  logic                   i_pop,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_full
);

    logic [DATA_WIDTH-1:0]  r_mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]  r_wr_ptr_q;
    logic [ADDR_WIDTH-1:0]  w_wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  r_rd_ptr_q;
    logic [ADDR_WIDTH-1:0]  w_rd_ptr_d;
    logic [COUNT_WIDTH-1:0] r_count_q;
    logic [COUNT_WIDTH-1:0] w_count_d;

    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    // Qualify requests so that the storage can never be over- or under-run,
    // then derive next pointers and occupancy (pointers wrap naturally since
    // DEPTH is a power of two).
    always_comb begin
        w_full     = (r_count_q == COUNT_WIDTH'(DEPTH));
        w_pop_ok   = i_pop && (r_count_q != '0);
        w_push_ok  = i_push && (!w_full || w_pop_ok);

        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;

        if (w_push_ok) begin
            w_wr_ptr_d = r_wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (w_pop_ok) begin
            w_rd_ptr_d = r_rd_ptr_q + ADDR_WIDTH'(1);
        end

        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_d = r_count_q + COUNT_WIDTH'(1);
            2'b01:   w_count_d = r_count_q - COUNT_WIDTH'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage array; contents are left untouched by reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem_q[r_wr_ptr_q] <= i_push_data;
        end
    end

    assign o_data  = r_mem_q[r_rd_ptr_q];
    assign o_count = r_count_q;
    assign o_full  = w_full;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_buffer
//  Description : Receive-side elastic buffer behind the UART receiver.
//                Captures strobed bytes into a FIFO, presents them over a
//                valid/ready interface, and tracks overflow and framing
//                errors with sticky/saturating status.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int DEPTH      = c_DEF_DEPTH,
    parameter int CNT_WIDTH  = c_DEF_CNT_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rx_dv,
    input  logic [DATA_WIDTH-1:0]      i_rx_byte,
    input  logic                       i_rx_error,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_overflow,
    output logic [CNT_WIDTH-1:0]       o_drop_count,
    output logic [CNT_WIDTH-1:0]       o_err_count,
    input  logic                       i_clr_status
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [$clog2(DEPTH):0] w_fifo_count;
    logic                   w_fifo_full;
    logic                   w_pop;
    rx_action_e             w_rx_action;

    logic                   r_err_prev_q;
    logic                   w_err_prev_d;
    logic                   w_err_rise;

    logic                   r_overflow_q;
    logic                   w_overflow_d;
    logic [CNT_WIDTH-1:0]   r_drop_count_q;
    logic [CNT_WIDTH-1:0]   w_drop_count_d;
    logic [CNT_WIDTH-1:0]   r_err_count_q;
    logic [CNT_WIDTH-1:0]   w_err_count_d;

    // Decide the fate of an incoming byte: a full FIFO still accepts it when
    // the consumer frees a slot in the same cycle.
    always_comb begin
        w_pop       = o_valid && i_ready;
        w_rx_action = ACT_IDLE;
        if (i_rx_dv) begin
            if (!w_fifo_full || w_pop) begin
                w_rx_action = ACT_PUSH;
            end else begin
                w_rx_action = ACT_DROP;
            end
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_rx_action == ACT_PUSH),
        .i_push_data (i_rx_byte),
        .i_pop       (w_pop),
        .o_data      (o_data),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full)
    );

    // Status next-state: clear takes effect first, then a same-cycle drop or
    // error edge is counted on top of the cleared value; counters saturate.
    always_comb begin
        w_err_prev_d   = i_rx_error;
        w_err_rise     = i_rx_error && !r_err_prev_q;

        w_overflow_d   = i_clr_status ? 1'b0 : r_overflow_q;
        w_drop_count_d = i_clr_status ? '0   : r_drop_count_q;
        w_err_count_d  = i_clr_status ? '0   : r_err_count_q;

        if (w_rx_action == ACT_DROP) begin
            w_overflow_d = 1'b1;
            if (w_drop_count_d != c_CNT_MAX) begin
                w_drop_count_d = w_drop_count_d + CNT_WIDTH'(1);
            end
        end

        if (w_err_rise && (w_err_count_d != c_CNT_MAX)) begin
            w_err_count_d = w_err_count_d + CNT_WIDTH'(1);
        end
    end

    // Status registers and the framing-error edge detector.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_prev_q   <= 1'b0;
            r_overflow_q   <= 1'b0;
            r_drop_count_q <= '0;
            r_err_count_q  <= '0;
        end else begin
            r_err_prev_q   <= w_err_prev_d;
            r_overflow_q   <= w_overflow_d;
            r_drop_count_q <= w_drop_count_d;
            r_err_count_q  <= w_err_count_d;
        end
    end

    assign o_count      = w_fifo_count;
    assign o_valid      = (w_fifo_count != '0);
    assign o_full       = w_fifo_full;
    assign o_overflow   = r_overflow_q;
    assign o_drop_count = r_drop_count_q;
    assign o_err_count  = r_err_count_q;

endmodule : uart_rx_buffer
`default_nettype wire
